// File: rtl/ft245_rx_cmd.sv
// FT245 receive path: drains host bytes with RXF#/RD# and decodes 5-byte
// command frames (A5, op, arg_hi, arg_lo, csum) onto a valid/ready port.
module ft245_rx_cmd #(
  parameter int unsigned RD_LOW_CYC  = 3,
  parameter int unsigned RD_HIGH_CYC = 4,
  parameter int unsigned TIMEOUT_CYC = 500000,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ft_d,
  input  logic        ft_rxf_n,
  output logic        ft_rd_n,
  input  logic        rx_en,
  output logic        rx_busy,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_op,
  output logic [15:0] cmd_arg,
  output logic        err_pulse,
  output logic [1:0]  err_code
);

  localparam int unsigned BUS_MAX   = (RD_LOW_CYC > RD_HIGH_CYC) ? RD_LOW_CYC : RD_HIGH_CYC;
  localparam int unsigned BUS_W     = $clog2(BUS_MAX + 1);
  localparam int unsigned TMO_MIN_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned TMO_W     = (TMO_MIN_W > 19) ? TMO_MIN_W : 19;

  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    B_IDLE,
    B_RD_LOW,
    B_RD_HIGH
  } bus_state_t;

  typedef enum logic [2:0] {
    P_HDR,
    P_OP,
    P_AH,
    P_AL,
    P_CS
  } prs_state_t;

  // RXF# synchronizer
  logic rxf_meta;
  logic rxf_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxf_meta <= 1'b1;
      rxf_s    <= 1'b1;
    end else begin
      rxf_meta <= ft_rxf_n;
      rxf_s    <= rxf_meta;
    end
  end

  // Bus FSM: RD# strobe generation and byte capture
  bus_state_t       bus_state;
  bus_state_t       bus_state_nx;
  logic [BUS_W-1:0] bus_cnt;
  logic [BUS_W-1:0] bus_cnt_nx;
  logic [7:0]       byte_q;
  logic [7:0]       byte_nx;
  logic             byte_stb;
  logic             byte_stb_nx;
  logic             rd_n_nx;
  logic             busy_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_state <= B_IDLE;
      bus_cnt   <= '0;
      byte_q    <= '0;
      byte_stb  <= 1'b0;
      ft_rd_n   <= 1'b1;
      rx_busy   <= 1'b0;
    end else begin
      bus_state <= bus_state_nx;
      bus_cnt   <= bus_cnt_nx;
      byte_q    <= byte_nx;
      byte_stb  <= byte_stb_nx;
      ft_rd_n   <= rd_n_nx;
      rx_busy   <= busy_nx;
    end
  end

  always_comb begin
    bus_state_nx = bus_state;
    bus_cnt_nx   = bus_cnt;
    byte_nx      = byte_q;
    byte_stb_nx  = 1'b0;
    case (bus_state)
      B_IDLE: begin
        // A pending command stalls reads so the FT245 FIFO absorbs backpressure
        if (rx_en && !rxf_s && !cmd_valid) begin
          bus_state_nx = B_RD_LOW;
          bus_cnt_nx   = '0;
        end
      end
      B_RD_LOW: begin
        if (bus_cnt == BUS_W'(RD_LOW_CYC - 1)) begin
          bus_state_nx = B_RD_HIGH;
          bus_cnt_nx   = '0;
          byte_nx      = ft_d;
          byte_stb_nx  = 1'b1;
        end else begin
          bus_cnt_nx = bus_cnt + BUS_W'(1);
        end
      end
      B_RD_HIGH: begin
        if (bus_cnt == BUS_W'(RD_HIGH_CYC - 1)) begin
          bus_state_nx = B_IDLE;
          bus_cnt_nx   = '0;
        end else begin
          bus_cnt_nx = bus_cnt + BUS_W'(1);
        end
      end
      default: begin
        bus_state_nx = B_IDLE;
        bus_cnt_nx   = '0;
      end
    endcase
    rd_n_nx = (bus_state_nx != B_RD_LOW);
    busy_nx = (bus_state_nx != B_IDLE);
  end

  // Frame parser with inter-byte timeout
  prs_state_t       prs_state;
  prs_state_t       prs_nx;
  logic [7:0]       op_q;
  logic [7:0]       op_nx;
  logic [7:0]       ah_q;
  logic [7:0]       ah_nx;
  logic [7:0]       al_q;
  logic [7:0]       al_nx;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_nx;
  logic             tmo_run;
  logic             tmo_hit;
  logic             cmd_valid_nx;
  logic [7:0]       cmd_op_nx;
  logic [15:0]      cmd_arg_nx;
  logic             err_pulse_nx;
  logic [1:0]       err_code_nx;

  assign tmo_run = (prs_state != P_HDR) && (bus_state == B_IDLE);
  assign tmo_hit = tmo_run && (tmo_cnt >= TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prs_state <= P_HDR;
      op_q      <= '0;
      ah_q      <= '0;
      al_q      <= '0;
      tmo_cnt   <= '0;
      cmd_valid <= 1'b0;
      cmd_op    <= '0;
      cmd_arg   <= '0;
      err_pulse <= 1'b0;
      err_code  <= '0;
    end else begin
      prs_state <= prs_nx;
      op_q      <= op_nx;
      ah_q      <= ah_nx;
      al_q      <= al_nx;
      tmo_cnt   <= tmo_nx;
      cmd_valid <= cmd_valid_nx;
      cmd_op    <= cmd_op_nx;
      cmd_arg   <= cmd_arg_nx;
      err_pulse <= err_pulse_nx;
      err_code  <= err_code_nx;
    end
  end

  always_comb begin
    prs_nx       = prs_state;
    op_nx        = op_q;
    ah_nx        = ah_q;
    al_nx        = al_q;
    tmo_nx       = tmo_cnt;
    cmd_valid_nx = cmd_valid;
    cmd_op_nx    = cmd_op;
    cmd_arg_nx   = cmd_arg;
    err_pulse_nx = 1'b0;
    err_code_nx  = err_code;

    if (cmd_valid && cmd_ready) begin
      cmd_valid_nx = 1'b0;
    end

    // A received byte takes priority over an expiring timeout
    if (byte_stb) begin
      tmo_nx = '0;
      case (prs_state)
        P_HDR: begin
          if (byte_q == HDR_BYTE) begin
            prs_nx = P_OP;
          end
        end
        P_OP: begin
          op_nx  = byte_q;
          prs_nx = P_AH;
        end
        P_AH: begin
          ah_nx  = byte_q;
          prs_nx = P_AL;
        end
        P_AL: begin
          al_nx  = byte_q;
          prs_nx = P_CS;
        end
        P_CS: begin
          prs_nx = P_HDR;
          if (byte_q == (op_q ^ ah_q ^ al_q)) begin
            cmd_valid_nx = 1'b1;
            cmd_op_nx    = op_q;
            cmd_arg_nx   = {ah_q, al_q};
          end else begin
            err_pulse_nx = 1'b1;
            err_code_nx  = ERR_CSUM;
          end
        end
        default: prs_nx = P_HDR;
      endcase
    end else if (tmo_hit) begin
      prs_nx       = P_HDR;
      tmo_nx       = '0;
      err_pulse_nx = 1'b1;
      err_code_nx  = ERR_TIMEOUT;
    end else if (tmo_run && (tmo_cnt != '1)) begin
      tmo_nx = tmo_cnt + TMO_W'(1);
    end
  end

endmodule
